// File: rtl/rom_lut128x8_pkg.sv
// Shared widths, types and a reference formula for the 128x8 lookup ROM.
// The formula is for models only; the RTL reads the explicit case table.
package rom_lut128x8_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 128;

   typedef logic [ADDR_W-1:0] rom_addr_t;
   typedef logic [DATA_W-1:0] rom_data_t;

   function automatic rom_data_t rom_entry(input rom_addr_t a);
      logic [15:0] p;
      p = 16'(a) * 16'd37 + 16'd11;
      return p[7:0];
   endfunction

endpackage

// File: rtl/rom_lut128x8_table.sv
// Combinational 128-entry constant table: entry[a] = (a*37 + 11) mod 256.
// The default arm keeps unknown addresses from propagating X downstream.
module rom_lut128x8_table
   import rom_lut128x8_pkg::*;
(
   input  rom_addr_t addr_i,
   output rom_data_t data_o
);

   always_comb begin
      data_o = 8'h00;
      case (addr_i)
         7'd0:   data_o = 8'h0B;
         7'd1:   data_o = 8'h30;
         7'd2:   data_o = 8'h55;
         7'd3:   data_o = 8'h7A;
         7'd4:   data_o = 8'h9F;
         7'd5:   data_o = 8'hC4;
         7'd6:   data_o = 8'hE9;
         7'd7:   data_o = 8'h0E;
         7'd8:   data_o = 8'h33;
         7'd9:   data_o = 8'h58;
         7'd10:  data_o = 8'h7D;
         7'd11:  data_o = 8'hA2;
         7'd12:  data_o = 8'hC7;
         7'd13:  data_o = 8'hEC;
         7'd14:  data_o = 8'h11;
         7'd15:  data_o = 8'h36;
         7'd16:  data_o = 8'h5B;
         7'd17:  data_o = 8'h80;
         7'd18:  data_o = 8'hA5;
         7'd19:  data_o = 8'hCA;
         7'd20:  data_o = 8'hEF;
         7'd21:  data_o = 8'h14;
         7'd22:  data_o = 8'h39;
         7'd23:  data_o = 8'h5E;
         7'd24:  data_o = 8'h83;
         7'd25:  data_o = 8'hA8;
         7'd26:  data_o = 8'hCD;
         7'd27:  data_o = 8'hF2;
         7'd28:  data_o = 8'h17;
         7'd29:  data_o = 8'h3C;
         7'd30:  data_o = 8'h61;
         7'd31:  data_o = 8'h86;
         7'd32:  data_o = 8'hAB;
         7'd33:  data_o = 8'hD0;
         7'd34:  data_o = 8'hF5;
         7'd35:  data_o = 8'h1A;
         7'd36:  data_o = 8'h3F;
         7'd37:  data_o = 8'h64;
         7'd38:  data_o = 8'h89;
         7'd39:  data_o = 8'hAE;
         7'd40:  data_o = 8'hD3;
         7'd41:  data_o = 8'hF8;
         7'd42:  data_o = 8'h1D;
         7'd43:  data_o = 8'h42;
         7'd44:  data_o = 8'h67;
         7'd45:  data_o = 8'h8C;
         7'd46:  data_o = 8'hB1;
         7'd47:  data_o = 8'hD6;
         7'd48:  data_o = 8'hFB;
         7'd49:  data_o = 8'h20;
         7'd50:  data_o = 8'h45;
         7'd51:  data_o = 8'h6A;
         7'd52:  data_o = 8'h8F;
         7'd53:  data_o = 8'hB4;
         7'd54:  data_o = 8'hD9;
         7'd55:  data_o = 8'hFE;
         7'd56:  data_o = 8'h23;
         7'd57:  data_o = 8'h48;
         7'd58:  data_o = 8'h6D;
         7'd59:  data_o = 8'h92;
         7'd60:  data_o = 8'hB7;
         7'd61:  data_o = 8'hDC;
         7'd62:  data_o = 8'h01;
         7'd63:  data_o = 8'h26;
         7'd64:  data_o = 8'h4B;
         7'd65:  data_o = 8'h70;
         7'd66:  data_o = 8'h95;
         7'd67:  data_o = 8'hBA;
         7'd68:  data_o = 8'hDF;
         7'd69:  data_o = 8'h04;
         7'd70:  data_o = 8'h29;
         7'd71:  data_o = 8'h4E;
         7'd72:  data_o = 8'h73;
         7'd73:  data_o = 8'h98;
         7'd74:  data_o = 8'hBD;
         7'd75:  data_o = 8'hE2;
         7'd76:  data_o = 8'h07;
         7'd77:  data_o = 8'h2C;
         7'd78:  data_o = 8'h51;
         7'd79:  data_o = 8'h76;
         7'd80:  data_o = 8'h9B;
         7'd81:  data_o = 8'hC0;
         7'd82:  data_o = 8'hE5;
         7'd83:  data_o = 8'h0A;
         7'd84:  data_o = 8'h2F;
         7'd85:  data_o = 8'h54;
         7'd86:  data_o = 8'h79;
         7'd87:  data_o = 8'h9E;
         7'd88:  data_o = 8'hC3;
         7'd89:  data_o = 8'hE8;
         7'd90:  data_o = 8'h0D;
         7'd91:  data_o = 8'h32;
         7'd92:  data_o = 8'h57;
         7'd93:  data_o = 8'h7C;
         7'd94:  data_o = 8'hA1;
         7'd95:  data_o = 8'hC6;
         7'd96:  data_o = 8'hEB;
         7'd97:  data_o = 8'h10;
         7'd98:  data_o = 8'h35;
         7'd99:  data_o = 8'h5A;
         7'd100: data_o = 8'h7F;
         7'd101: data_o = 8'hA4;
         7'd102: data_o = 8'hC9;
         7'd103: data_o = 8'hEE;
         7'd104: data_o = 8'h13;
         7'd105: data_o = 8'h38;
         7'd106: data_o = 8'h5D;
         7'd107: data_o = 8'h82;
         7'd108: data_o = 8'hA7;
         7'd109: data_o = 8'hCC;
         7'd110: data_o = 8'hF1;
         7'd111: data_o = 8'h16;
         7'd112: data_o = 8'h3B;
         7'd113: data_o = 8'h60;
         7'd114: data_o = 8'h85;
         7'd115: data_o = 8'hAA;
         7'd116: data_o = 8'hCF;
         7'd117: data_o = 8'hF4;
         7'd118: data_o = 8'h19;
         7'd119: data_o = 8'h3E;
         7'd120: data_o = 8'h63;
         7'd121: data_o = 8'h88;
         7'd122: data_o = 8'hAD;
         7'd123: data_o = 8'hD2;
         7'd124: data_o = 8'hF7;
         7'd125: data_o = 8'h1C;
         7'd126: data_o = 8'h41;
         7'd127: data_o = 8'h66;
         default: data_o = 8'h00;
      endcase
   end

endmodule

// File: rtl/rom_lut128x8.sv
// 128x8 ROM with registered output; ROM_ADDR_REG_EN adds an input
// address register for 2-cycle latency (default build: 1 cycle).
module rom_lut128x8
   import rom_lut128x8_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data
);

   rom_addr_t rd_addr;
   rom_data_t tbl_data;
   rom_data_t data_d;
   rom_data_t data_q;

`ifdef ROM_ADDR_REG_EN
   rom_addr_t addr_d;
   rom_addr_t addr_q;

   always_comb begin
      addr_d = address;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) addr_q <= '0;
      else        addr_q <= addr_d;
   end

   assign rd_addr = addr_q;
`else
   assign rd_addr = address;
`endif

   rom_lut128x8_table u_table (
      .addr_i (rd_addr),
      .data_o (tbl_data)
   );

   always_comb begin
      data_d = tbl_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= data_d;
   end

   assign data = data_q;

endmodule

// File: tb/tb_rom_lut128x8.sv
// Directed bench for rom_lut128x8; latency follows ROM_ADDR_REG_EN.
// Inputs change on the falling edge, outputs sampled 1 time unit after rise.
module tb_rom_lut128x8;
   import rom_lut128x8_pkg::*;

`ifdef ROM_ADDR_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic      clk;
   logic      rst_n;
   rom_addr_t address;
   rom_data_t data;

   int n_cmp;
   int n_bad;

   rom_lut128x8 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .address (address),
      .data    (data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      address = 7'd5;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_hold[%0d] got %h want 00", i, data);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
`ifdef ROM_ADDR_REG_EN
      @(posedge clk); #1;
      n_cmp++;
      if (data !== 8'h0B) begin
         n_bad++;
         $display("FAIL reset_rel_entry0 got %h want 0b", data);
      end
`endif
      @(posedge clk); #1;
      n_cmp++;
      if (data !== 8'hC4) begin
         n_bad++;
         $display("FAIL reset_release got %h want c4", data);
      end
   endtask

   task automatic test_directed();
      rom_addr_t va [5];
      rom_data_t vd [5];
      va = '{7'd0, 7'd1, 7'd7, 7'd64, 7'd127};
      vd = '{8'h0B, 8'h30, 8'h0E, 8'h4B, 8'h66};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         address = va[i];
         repeat (LAT) @(posedge clk);
         #1;
         n_cmp++;
         if (data !== vd[i]) begin
            n_bad++;
            $display("FAIL directed a=%0d got %h want %h",
                     va[i], data, vd[i]);
         end
      end
   endtask

   task automatic test_sweep();
      for (int i = 0; i < DEPTH + LAT - 1; i++) begin
         @(negedge clk);
         if (i < DEPTH) address = rom_addr_t'(i);
         @(posedge clk); #1;
         if (i >= LAT - 1) begin
            n_cmp++;
            if (data !== rom_entry(rom_addr_t'(i - LAT + 1))) begin
               n_bad++;
               $display("FAIL sweep a=%0d got %h want %h", i - LAT + 1,
                        data, rom_entry(rom_addr_t'(i - LAT + 1)));
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      address = 7'd39;
      @(posedge clk);
      @(negedge clk);
      address = 7'd40;
      @(posedge clk); #1;
      n_cmp++;
      if (data !== rom_entry(rom_addr_t'(40 - LAT + 1))) begin
         n_bad++;
         $display("FAIL mid_pre got %h want %h",
                  data, rom_entry(rom_addr_t'(40 - LAT + 1)));
      end
      @(negedge clk);
      rst_n   = 1'b0;
      address = 7'd41;
      @(posedge clk); #1;
      n_cmp++;
      if (data !== 8'h00) begin
         n_bad++;
         $display("FAIL mid_reset got %h want 00", data);
      end
      @(negedge clk);
      rst_n = 1'b1;
`ifdef ROM_ADDR_REG_EN
      @(posedge clk); #1;
      n_cmp++;
      if (data !== 8'h0B) begin
         n_bad++;
         $display("FAIL mid_rel_entry0 got %h want 0b", data);
      end
`endif
      @(posedge clk); #1;
      n_cmp++;
      if (data !== 8'hF8) begin
         n_bad++;
         $display("FAIL mid_resume got %h want f8", data);
      end
      @(negedge clk);
      address = 7'd42;
      repeat (LAT) @(posedge clk);
      #1;
      n_cmp++;
      if (data !== 8'h1D) begin
         n_bad++;
         $display("FAIL mid_next got %h want 1d", data);
      end
   endtask

   task automatic test_glitch();
      @(negedge clk);
      address = 7'd7;
      repeat (LAT) @(posedge clk);
      @(negedge clk);
      address = 7'd3;
      #1 address = 7'd9;
      #1;
      n_cmp++;
      if (data !== 8'h0E) begin
         n_bad++;
         $display("FAIL glitch_hold got %h want 0e", data);
      end
      #1 address = 7'd3;
      repeat (LAT) @(posedge clk);
      #1;
      n_cmp++;
      if (data !== 8'h7A) begin
         n_bad++;
         $display("FAIL glitch got %h want 7a", data);
      end
   endtask

   task automatic test_back_to_back();
      rom_addr_t va [4];
      rom_data_t vd [4];
      va = '{7'd127, 7'd0, 7'd62, 7'd17};
      vd = '{8'h66, 8'h0B, 8'h01, 8'h80};
      for (int i = 0; i < 4 + LAT - 1; i++) begin
         @(negedge clk);
         if (i < 4) address = va[i];
         @(posedge clk); #1;
         if (i >= LAT - 1) begin
            n_cmp++;
            if (data !== vd[i - LAT + 1]) begin
               n_bad++;
               $display("FAIL b2b[%0d] got %h want %h",
                        i - LAT + 1, data, vd[i - LAT + 1]);
            end
         end
      end
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      address = '0;
      test_reset();
      test_directed();
      test_sweep();
      test_mid_reset();
      test_glitch();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
